// File: rtl/uart_param_txrx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_param_txrx
//  Purpose  : Parametrised full-duplex UART. The TX and RX halves are fully
//             independent. Frames are sent LSB first, with an optional
//             parity bit and 1 or 2 stop bits. Both sides use valid/ready
//             handshakes.
//             RX has a 2-flop input synchroniser, false-start rejection,
//             parity/framing/overrun flags and a 1-entry holding register.
//  Ports    : clk, rst (asynchronous, active-high)
//             tx_data/tx_valid/tx_ready : word to transmit, handshake
//             tx_out, tx_busy           : serial line (idle high), frame busy
//             rx_in                     : asynchronous serial line in
//             rx_data/rx_valid/rx_ready : received word, handshake
//             rx_parity_err, rx_frame_err, rx_overrun : status for rx_data
//  Revision : 1.0  initial release
// ============================================================================
module uart_param_txrx #(
  parameter int CLKS_PER_BIT = 521,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = $clog2(DATA_BITS) + 1;

  localparam logic [CW-1:0] c_cnt_one  = CW'(1);
  localparam logic [CW-1:0] c_bit_end  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_stop_end = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_half_end = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] c_idx_one  = BW'(1);
  localparam logic [BW-1:0] c_idx_last = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Even parity is the XOR of the data; odd parity is its inverse.
  function automatic logic par_of(input logic [DATA_BITS-1:0] d);
    return (PARITY_MODE == 2) ? ~^d : ^d;
  endfunction

  // --------------------------------------------------------------------------
  // Transmitter
  // --------------------------------------------------------------------------
  state_t                tx_state_q, tx_state_d;
  logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]         tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0]  tx_shift_q, tx_shift_d;
  logic                  tx_par_q, tx_par_d;
  logic                  tx_out_q, tx_out_d;
  logic                  tx_ready_q, tx_ready_d;
  logic                  tx_busy_q, tx_busy_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_out_d   = tx_out_q;
    tx_ready_d = tx_ready_q;
    tx_busy_d  = tx_busy_q;
    case (tx_state_q)
      S_IDLE: begin
        if (tx_valid && tx_ready_q) begin
          tx_shift_d = tx_data;
          tx_par_d   = par_of(tx_data);
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_out_d   = 1'b0;
          tx_ready_d = 1'b0;
          tx_busy_d  = 1'b1;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == c_bit_end) begin
          tx_cnt_d   = '0;
          tx_out_d   = tx_shift_q[0];
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + c_cnt_one;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == c_bit_end) begin
          tx_cnt_d = '0;
          if (tx_idx_q == c_idx_last) begin
            if (PARITY_MODE != 0) begin
              tx_out_d   = tx_par_q;
              tx_state_d = S_PARITY;
            end else begin
              tx_out_d   = 1'b1;
              tx_state_d = S_STOP;
            end
          end else begin
            // The line always carries bit 0 of the shift register.
            tx_idx_d   = tx_idx_q + c_idx_one;
            tx_shift_d = tx_shift_q >> 1;
            tx_out_d   = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + c_cnt_one;
        end
      end
      S_PARITY: begin
        if (tx_cnt_q == c_bit_end) begin
          tx_cnt_d   = '0;
          tx_out_d   = 1'b1;
          tx_state_d = S_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + c_cnt_one;
        end
      end
      S_STOP: begin
        // All stop bits are timed as one stretched period.
        if (tx_cnt_q == c_stop_end) begin
          tx_cnt_d   = '0;
          tx_ready_d = 1'b1;
          tx_busy_d  = 1'b0;
          tx_state_d = S_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + c_cnt_one;
        end
      end
      default: begin
        tx_cnt_d   = '0;
        tx_out_d   = 1'b1;
        tx_ready_d = 1'b1;
        tx_busy_d  = 1'b0;
        tx_state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_out_q   <= tx_out_d;
      tx_ready_q <= tx_ready_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  assign tx_out   = tx_out_q;
  assign tx_ready = tx_ready_q;
  assign tx_busy  = tx_busy_q;

  // --------------------------------------------------------------------------
  // Receiver
  // --------------------------------------------------------------------------
  logic                  rx_sync1_q, rx_sync2_q;
  state_t                rx_state_q, rx_state_d;
  logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]         rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0]  rx_shift_q, rx_shift_d;
  logic                  rx_perr_pend_q, rx_perr_pend_d;
  logic                  rx_wait_high_q, rx_wait_high_d;
  logic                  rx_load, rx_load_ferr;

  logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_perr_q, rx_perr_d;
  logic                  rx_ferr_q, rx_ferr_d;
  logic                  rx_ovr_q, rx_ovr_d;

  always_comb begin
    rx_state_d     = rx_state_q;
    rx_cnt_d       = rx_cnt_q;
    rx_idx_d       = rx_idx_q;
    rx_shift_d     = rx_shift_q;
    rx_perr_pend_d = rx_perr_pend_q;
    rx_wait_high_d = rx_wait_high_q;
    rx_load        = 1'b0;
    rx_load_ferr   = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        // After a framing error the line may be held low (break). A new
        // start is only recognised once the line has returned high.
        if (rx_wait_high_q) begin
          if (rx_sync2_q) rx_wait_high_d = 1'b0;
        end else if (!rx_sync2_q) begin
          rx_cnt_d       = '0;
          rx_perr_pend_d = 1'b0;
          rx_state_d     = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_q == c_half_end) begin
          rx_cnt_d = '0;
          rx_idx_d = '0;
          // A line that is high again at mid-start is a glitch.
          rx_state_d = rx_sync2_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + c_cnt_one;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == c_bit_end) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_idx_q == c_idx_last) begin
            rx_idx_d   = '0;
            rx_state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            rx_idx_d = rx_idx_q + c_idx_one;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + c_cnt_one;
        end
      end
      S_PARITY: begin
        if (rx_cnt_q == c_bit_end) begin
          rx_cnt_d       = '0;
          rx_perr_pend_d = rx_sync2_q ^ par_of(rx_shift_q);
          rx_state_d     = S_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + c_cnt_one;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == c_bit_end) begin
          rx_cnt_d       = '0;
          rx_load        = 1'b1;
          rx_load_ferr   = ~rx_sync2_q;
          rx_wait_high_d = ~rx_sync2_q;
          rx_state_d     = S_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + c_cnt_one;
        end
      end
      default: begin
        rx_cnt_d   = '0;
        rx_state_d = S_IDLE;
      end
    endcase
  end

  // Holding register: a load always wins over a simultaneous accept.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_ovr_d   = rx_ovr_q;
    if (rx_load) begin
      rx_data_d  = rx_shift_q;
      rx_perr_d  = rx_perr_pend_q;
      rx_ferr_d  = rx_load_ferr;
      rx_valid_d = 1'b1;
      // Overrun only when the previous word was neither consumed now nor
      // before; an accept in the same cycle clears it.
      rx_ovr_d   = rx_valid_q & ~rx_ready;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
      rx_ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync1_q     <= 1'b1;
      rx_sync2_q     <= 1'b1;
      rx_state_q     <= S_IDLE;
      rx_cnt_q       <= '0;
      rx_idx_q       <= '0;
      rx_shift_q     <= '0;
      rx_perr_pend_q <= 1'b0;
      rx_wait_high_q <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_perr_q      <= 1'b0;
      rx_ferr_q      <= 1'b0;
      rx_ovr_q       <= 1'b0;
    end else begin
      rx_sync1_q     <= rx_in;
      rx_sync2_q     <= rx_sync1_q;
      rx_state_q     <= rx_state_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_idx_q       <= rx_idx_d;
      rx_shift_q     <= rx_shift_d;
      rx_perr_pend_q <= rx_perr_pend_d;
      rx_wait_high_q <= rx_wait_high_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rx_perr_q      <= rx_perr_d;
      rx_ferr_q      <= rx_ferr_d;
      rx_ovr_q       <= rx_ovr_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_overrun    = rx_ovr_q;

endmodule
`default_nettype wire
